// File: rtl/dm_cache_pkg.sv
// Shared types for the direct-mapped cache controller: FSM states, request records, line geometry.
package dm_cache_pkg;
  localparam int ADDR_W       = 32;
  localparam int WORD_W       = 32;
  localparam int LINE_W       = 512;
  localparam int OFFSET_WIDTH = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    WRITE_BACK = 3'd2,
    ALLOCATE   = 3'd3,
    REFILL     = 3'd4,
    LOOKUP     = 3'd5
  } cache_state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } cpu_req_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mem_req_t;
endpackage

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller. Drives an external tag RAM and
// line data RAM (both 1-cycle read latency) and a line-wide memory port.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int CACHE_LINES      = 8,
  parameter int CACHE_LINE_WIDTH = $clog2(CACHE_LINES),
  parameter int LINE_WIDTH       = LINE_W,
  parameter int WORD_WIDTH       = WORD_W,
  parameter int TAG_WIDTH        = 32 - CACHE_LINE_WIDTH - OFFSET_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req_valid,
  input  logic                        cpu_req_rw,
  input  logic [31:0]                 cpu_req_addr,
  input  logic [WORD_WIDTH-1:0]       cpu_req_data,
  output logic                        cpu_res_ready,
  output logic [WORD_WIDTH-1:0]       cpu_res_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_rw,
  output logic [31:0]                 mem_req_addr,
  output logic [LINE_WIDTH-1:0]       mem_req_data,
  input  logic                        mem_req_ready,
  input  logic                        mem_res_valid,
  input  logic [LINE_WIDTH-1:0]       mem_res_data,
  output logic [CACHE_LINE_WIDTH-1:0] tag_req_index,
  output logic                        tag_req_we,
  output logic                        tag_write_valid,
  output logic                        tag_write_dirty,
  output logic [TAG_WIDTH-1:0]        tag_write_tag,
  input  logic                        tag_read_valid,
  input  logic                        tag_read_dirty,
  input  logic [TAG_WIDTH-1:0]        tag_read_tag,
  output logic [CACHE_LINE_WIDTH-1:0] data_req_index,
  output logic                        data_req_we,
  output logic [LINE_WIDTH-1:0]       data_write,
  input  logic [LINE_WIDTH-1:0]       data_read
);
  localparam int WSEL_W = OFFSET_WIDTH - 2;

  cache_state_e                state, state_nxt;
  cpu_req_t                    req;
  logic [LINE_WIDTH-1:0]       victim_line;
  logic [TAG_WIDTH-1:0]        victim_tag;
  mem_req_t                    mreq;

  logic [TAG_WIDTH-1:0]        req_tag;
  logic [CACHE_LINE_WIDTH-1:0] req_idx;
  logic [WSEL_W-1:0]           req_word;
  logic                        hit, victim_dirty;
  logic [WORD_WIDTH-1:0]       rd_word;
  logic [LINE_WIDTH-1:0]       merged;
  logic                        unused_addr_bits;

  assign req_tag          = req.addr[31 -: TAG_WIDTH];
  assign req_idx          = req.addr[OFFSET_WIDTH +: CACHE_LINE_WIDTH];
  assign req_word         = req.addr[2 +: WSEL_W];
  assign hit              = tag_read_valid && (tag_read_tag == req_tag);
  assign victim_dirty     = tag_read_valid && tag_read_dirty;
  assign rd_word          = data_read[req_word*WORD_WIDTH +: WORD_WIDTH];
  assign unused_addr_bits = ^req.addr[1:0];

  always_comb begin
    merged = data_read;
    merged[req_word*WORD_WIDTH +: WORD_WIDTH] = req.data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req         <= '0;
      victim_line <= '0;
      victim_tag  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_req_valid)
        req <= '{rw: cpu_req_rw, addr: cpu_req_addr, data: cpu_req_data};
      if (state == COMPARE && !hit && victim_dirty) begin
        victim_line <= data_read;
        victim_tag  <= tag_read_tag;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    mreq            = '0;
    cpu_res_ready   = 1'b0;
    cpu_res_data    = '0;
    tag_req_we      = 1'b0;
    tag_write_valid = 1'b0;
    tag_write_dirty = 1'b0;
    tag_write_tag   = '0;
    data_req_we     = 1'b0;
    data_write      = '0;
    tag_req_index   = (state == IDLE) ? cpu_req_addr[OFFSET_WIDTH +: CACHE_LINE_WIDTH] : req_idx;
    case (state)
      IDLE: if (cpu_req_valid) state_nxt = COMPARE;
      COMPARE: begin
        if (hit) begin
          cpu_res_ready = 1'b1;
          cpu_res_data  = rd_word;
          if (req.rw) begin
            tag_req_we      = 1'b1;
            tag_write_valid = 1'b1;
            tag_write_dirty = 1'b1;
            tag_write_tag   = req_tag;
            data_req_we     = 1'b1;
            data_write      = merged;
          end
          state_nxt = IDLE;
        end else begin
          state_nxt = victim_dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      // Everything here comes from registers, so the request holds steady while stalled.
      WRITE_BACK: begin
        mreq = '{rw: 1'b1, addr: {victim_tag, req_idx, {OFFSET_WIDTH{1'b0}}}, data: victim_line};
        if (mem_req_ready) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mreq = '{rw: 1'b0, addr: {req_tag, req_idx, {OFFSET_WIDTH{1'b0}}}, data: '0};
        if (mem_req_ready) state_nxt = REFILL;
      end
      REFILL: begin
        if (mem_res_valid) begin
          data_req_we     = 1'b1;
          data_write      = mem_res_data;
          tag_req_we      = 1'b1;
          tag_write_valid = 1'b1;
          tag_write_tag   = req_tag;
          state_nxt       = LOOKUP;
        end
      end
      // The tag RAM is read-first, so the refill write is not visible until one more read.
      LOOKUP: state_nxt = COMPARE;
      default: state_nxt = IDLE;
    endcase
    data_req_index = tag_req_index;
    mem_req_valid  = (state == WRITE_BACK) || (state == ALLOCATE);
    mem_req_rw     = mreq.rw;
    mem_req_addr   = mreq.addr;
    mem_req_data   = mreq.data;
    if (!rst_n) begin
      cpu_res_ready   = 1'b0;
      cpu_res_data    = '0;
      mem_req_valid   = 1'b0;
      mem_req_rw      = 1'b0;
      mem_req_addr    = '0;
      mem_req_data    = '0;
      tag_req_index   = '0;
      data_req_index  = '0;
      tag_req_we      = 1'b0;
      tag_write_valid = 1'b0;
      tag_write_dirty = 1'b0;
      tag_write_tag   = '0;
      data_req_we     = 1'b0;
      data_write      = '0;
    end
  end
endmodule
